// File: rtl/dmem_port_pkg.sv
// Shared definitions for the data-memory port.
//   - funct3 access codes (MEM_B/H/W/BU/HU)
//   - FSM state type dmem_state_e {IDLE, BUSY, DONE}
//   - default base address of word 0 (DMEM_BASE_ADDR)
//   - access_size(): funct3 -> byte/half/word (unused codes act as word)
//   - load_extend(): selects the addressed lane and sign/zero extends it
package dmem_port_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h0100_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } access_size_e;

    function automatic access_size_e access_size(input logic [2:0] funct3);
        access_size_e sz;
        case (funct3)
            MEM_B, MEM_BU: sz = SZ_B;
            MEM_H, MEM_HU: sz = SZ_H;
            default:       sz = SZ_W;
        endcase
        return sz;
    endfunction

    // Halves only look at lane[1] and words ignore the lane, so callers get
    // natural-alignment behaviour for free.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            MEM_B:   r = {{24{b[7]}}, b};
            MEM_BU:  r = {24'b0, b};
            MEM_H:   r = {{16{h[15]}}, h};
            MEM_HU:  r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-lane data RAM: DEPTH_WORDS x 32 bits, byte-enable write, registered read.
// Ports:
//   clk    clock
//   we     write enable (bytes selected by be)
//   be     4-bit byte enable, bit i writes bits [8i+7:8i]
//   re     read enable; rdata is updated at the next rising edge
//   addr   word index shared by read and write
//   wdata  write data, already steered onto its lanes
//   rdata  registered read data, held while re is low
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_port.sv
// Data-memory responder for the memory stage: byte/half/word loads and stores
// against dmem_array with a fixed LATENCY, stalling the pipeline meanwhile.
// Optional macro DMEM_MISALIGN_CHECK_EN: flag misaligned H/W accesses, drop
// such stores and return 0 for such loads. Without it low address bits are
// ignored (natural alignment is forced) and misalign_o stays 0.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   memren_i    load request          memwren_i  store request (wins if both)
//   funct3_i    access size/sign      addr_i     byte address
//   wdata_i     store data            stall_o    pipeline hold
//   rvalid_o    load data valid pulse rdata_o    extended load data (held)
//   misalign_o  misaligned access pulse, in the completion cycle
module dmem_port
    import dmem_port_pkg::*;
#(
    parameter int unsigned       DWIDTH      = 32,
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter int unsigned       LATENCY     = 2,
    parameter logic [DWIDTH-1:0] BASE_ADDR   = DWIDTH'(DMEM_BASE_ADDR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic [2:0]        funct3_i,
    input  logic [DWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    output logic              stall_o,
    output logic              rvalid_o,
    output logic [DWIDTH-1:0] rdata_o,
    output logic              misalign_o
);

    localparam int unsigned   AW       = $clog2(DEPTH_WORDS);
    localparam int unsigned   CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("dmem_port: LATENCY must be at least 1");
    end
    if (DWIDTH != 32) begin : g_bad_width
        $error("dmem_port: DWIDTH must be 32");
    end
    if (DEPTH_WORDS < 2) begin : g_bad_depth
        $error("dmem_port: DEPTH_WORDS must be at least 2");
    end

    dmem_state_e       state_q;
    logic [CW-1:0]     cnt_q;
    logic [DWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [2:0]        funct3_q;
    logic              store_q;
    // Describe the most recent load so rdata_o holds until the next one.
    logic [2:0]        ld_funct3_q;
    logic [1:0]        ld_lane_q;
    logic              ld_zero_q;

    logic              req;
    logic              idle;
    logic              cur_store;
    logic              finishing;
    logic              rd_en;
    logic              wr_en;
    logic              in_range;
    logic              misaligned;
    logic [DWIDTH-1:0] cur_addr;
    logic [DWIDTH-1:0] offset;
    logic [2:0]        cur_funct3;
    access_size_e      cur_size;
    logic [3:0]        be;
    logic [31:0]       lane_wdata;
    logic [31:0]       arr_rdata;

    assign req  = memren_i | memwren_i;
    assign idle = (state_q == IDLE);

    // While idle the live inputs are the access being accepted; afterwards
    // only the copy latched at acceptance counts.
    assign cur_addr   = idle ? addr_i : addr_q;
    assign cur_funct3 = idle ? funct3_i : funct3_q;
    assign cur_store  = idle ? memwren_i : store_q;
    assign cur_size   = access_size(cur_funct3);

    // Wrapping subtraction: addresses below the base land far out of range.
    assign offset   = cur_addr - BASE_ADDR;
    assign in_range = (offset >> 2) < DWIDTH'(DEPTH_WORDS);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = ((cur_size == SZ_H) && cur_addr[0]) ||
                        ((cur_size == SZ_W) && (cur_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // The edge ending this cycle moves the FSM into DONE.
    assign finishing = idle ? (req && (LATENCY == 1))
                            : ((state_q == BUSY) && (cnt_q == CW'(1)));
    // The array read is issued on that edge so its registered output lines
    // up with the DONE cycle.
    assign rd_en = finishing && !cur_store;
    assign wr_en = (state_q == DONE) && store_q && in_range && !misaligned && !reset;

    assign stall_o = idle ? req : (state_q == BUSY);

    always_comb begin
        be         = 4'b1111;
        lane_wdata = wdata_q;
        case (cur_size)
            SZ_B: begin
                be         = 4'b0001 << cur_addr[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            SZ_H: begin
                be         = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .we   (wr_en),
        .be   (be),
        .re   (rd_en),
        .addr (offset[AW+1:2]),
        .wdata(lane_wdata),
        .rdata(arr_rdata)
    );

    assign rdata_o = ld_zero_q ? '0 : DWIDTH'(load_extend(arr_rdata, ld_funct3_q, ld_lane_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            store_q     <= 1'b0;
            rvalid_o    <= 1'b0;
            misalign_o  <= 1'b0;
            ld_funct3_q <= MEM_W;
            ld_lane_q   <= '0;
            ld_zero_q   <= 1'b1;
        end else begin
            rvalid_o   <= rd_en;
            misalign_o <= finishing && misaligned;
            if (rd_en) begin
                ld_funct3_q <= cur_funct3;
                ld_lane_q   <= cur_addr[1:0];
                ld_zero_q   <= !in_range || misaligned;
            end
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q   <= addr_i;
                        wdata_q  <= wdata_i;
                        funct3_q <= funct3_i;
                        store_q  <= memwren_i;
                        cnt_q    <= CNT_INIT;
                        state_q  <= (LATENCY > 1) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: directed scenarios plus randomized
// accesses, compared against a byte-addressed memory model.
module tb_dmem_port;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        memren;
    logic        memwren;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        rvalid;
    logic [31:0] rdata;
    logic        misalign;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rdata;
    logic [7:0]  mem_model [int unsigned];
    logic [2:0]  f3_list [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};

    dmem_port #(
        .DWIDTH     (32),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memren_i  (memren),
        .memwren_i (memwren),
        .funct3_i  (funct3),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .stall_o   (stall),
        .rvalid_o  (rvalid),
        .rdata_o   (rdata),
        .misalign_o(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < DEPTH * 4;
    endfunction

    function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
        bit chk_en;
`ifdef DMEM_MISALIGN_CHECK_EN
        chk_en = 1'b1;
`else
        chk_en = 1'b0;
`endif
        return chk_en && ((a % size_of(f3)) != 0);
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int unsigned sz;
        logic [31:0] off;
        sz = size_of(f3);
        if (!in_rng(a) || is_mis(f3, a)) return;
        off = (a - BASE) & ~(sz - 1);
        for (int unsigned i = 0; i < sz; i++) mem_model[off + i] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        logic [31:0] off;
        logic [31:0] v;
        sz = size_of(f3);
        v  = '0;
        if (!in_rng(a) || is_mis(f3, a)) return '0;
        off = (a - BASE) & ~(sz - 1);
        for (int unsigned i = 0; i < sz; i++) begin
            if (mem_model.exists(off + i)) v = v | (32'(mem_model[off + i]) << (8 * i));
        end
        if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // Starts at the drive point of an idle cycle; returns at the drive point
    // of the first cycle after DONE. Inputs are scrambled while busy.
    task automatic access(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic [31:0] exp_rd;
        bit          exp_rv;
        bit          exp_mis;
        exp_rv  = ld && !st;
        exp_mis = is_mis(f3, a);
        exp_rd  = exp_rv ? model_load(f3, a) : last_rdata;
        memren = ld; memwren = st; funct3 = f3; addr = a; wdata = wd;
        #4;
        chk({tag, ":stall_T"}, 32'(stall), 32'd1);
        chk({tag, ":rvalid_T"}, 32'(rvalid), 32'd0);
        for (int unsigned k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            if (k < LAT) begin
                memren  = 1'($urandom_range(0, 1));
                memwren = 1'($urandom_range(0, 1));
                funct3  = 3'($urandom_range(0, 7));
                addr    = $urandom();
                wdata   = $urandom();
            end else begin
                memren = 1'b0; memwren = 1'b0;
            end
            #4;
            chk($sformatf("%s:stall_%0d", tag, k), 32'(stall), (k < LAT) ? 32'd1 : 32'd0);
            chk($sformatf("%s:rvalid_%0d", tag, k), 32'(rvalid),
                (k == LAT) ? 32'(exp_rv) : 32'd0);
            chk($sformatf("%s:misalign_%0d", tag, k), 32'(misalign),
                (k == LAT) ? 32'(exp_mis) : 32'd0);
            if (k == LAT) chk({tag, ":rdata"}, rdata, exp_rd);
        end
        if (st) model_store(f3, a, wd);
        last_rdata = exp_rd;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rw;
        logic [2:0]  rf;
        int unsigned op;
        int unsigned sel;
        int          rv_count;

        reset = 1'b1; memren = 1'b0; memwren = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        last_rdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #4;
        chk("reset:stall", 32'(stall), 32'd0);
        chk("reset:rvalid", 32'(rvalid), 32'd0);
        chk("reset:rdata", rdata, 32'd0);
        chk("reset:misalign", 32'(misalign), 32'd0);
        @(posedge clk); #1;

        for (int unsigned w = 0; w < 16; w++) access(0, 1, 3'b010, BASE + 4 * w, $urandom(), "init");

        access(0, 1, 3'b010, 32'h0100_0010, 32'hDEAD_BEEF, "sw_deadbeef");
        access(1, 0, 3'b010, 32'h0100_0010, 32'h0, "lw_deadbeef");
        chk("lw_deadbeef:const", rdata, 32'hDEAD_BEEF);

        access(0, 1, 3'b000, 32'h0100_0013, 32'h0000_0080, "sb_80");
        access(1, 0, 3'b000, 32'h0100_0013, 32'h0, "lb_80");
        chk("lb_80:const", rdata, 32'hFFFF_FF80);
        access(1, 0, 3'b100, 32'h0100_0013, 32'h0, "lbu_80");
        chk("lbu_80:const", rdata, 32'h0000_0080);
        access(1, 0, 3'b010, 32'h0100_0010, 32'h0, "lw_80adbeef");
        chk("lw_80adbeef:const", rdata, 32'h80AD_BEEF);

        // Load held through DONE, then a store: second acceptance at T+3.
        rv_count = 0;
        memren = 1'b1; memwren = 1'b0; funct3 = 3'b010; addr = 32'h0100_0010; wdata = '0;
        #4 chk("b2b:stall_T", 32'(stall), 32'd1); rv_count += int'(rvalid);
        @(posedge clk); #5 chk("b2b:stall_T1", 32'(stall), 32'd1); rv_count += int'(rvalid);
        @(posedge clk); #5;
        chk("b2b:stall_T2", 32'(stall), 32'd0);
        chk("b2b:rdata_T2", rdata, 32'h80AD_BEEF);
        rv_count += int'(rvalid);
        @(posedge clk); #1;
        memren = 1'b0; memwren = 1'b1; addr = 32'h0100_0030; wdata = 32'h5A5A_0F0F;
        #4 chk("b2b:stall_T3", 32'(stall), 32'd1); rv_count += int'(rvalid);
        @(posedge clk); #5 chk("b2b:stall_T4", 32'(stall), 32'd1); rv_count += int'(rvalid);
        @(posedge clk); #1 memwren = 1'b0;
        #4 chk("b2b:stall_T5", 32'(stall), 32'd0); rv_count += int'(rvalid);
        chk("b2b:rdata_hold", rdata, 32'h80AD_BEEF);
        @(posedge clk); #5 chk("b2b:stall_T6", 32'(stall), 32'd0); rv_count += int'(rvalid);
        chk("b2b:rvalid_count", 32'(rv_count), 32'd1);
        model_store(3'b010, 32'h0100_0030, 32'h5A5A_0F0F);
        last_rdata = 32'h80AD_BEEF;
        @(posedge clk); #1;
        access(1, 0, 3'b010, 32'h0100_0030, 32'h0, "b2b_lw");
        chk("b2b_lw:const", rdata, 32'h5A5A_0F0F);

        access(0, 1, 3'b010, 32'h0000_0000, 32'hCAFE_F00D, "sw_oor");
        access(1, 0, 3'b010, 32'h0000_0000, 32'h0, "lw_oor");
        chk("lw_oor:const", rdata, 32'h0);
        access(0, 1, 3'b010, BASE + DEPTH * 4 - 4, 32'h1357_9BDF, "sw_last");
        access(1, 0, 3'b010, BASE + DEPTH * 4 - 4, 32'h0, "lw_last");
        chk("lw_last:const", rdata, 32'h1357_9BDF);
        access(1, 0, 3'b010, BASE + DEPTH * 4, 32'h0, "lw_past_end");
        access(1, 0, 3'b010, 32'h0100_0000, 32'h0, "lw_after_oor");

        // Reset during BUSY of a store: store must be discarded.
        memren = 1'b0; memwren = 1'b1; funct3 = 3'b010; addr = 32'h0100_0020;
        wdata = 32'h1234_5678;
        #4 chk("rst_busy:stall_T", 32'(stall), 32'd1);
        @(posedge clk); #1 reset = 1'b1; memwren = 1'b0;
        #4 chk("rst_busy:stall_T1", 32'(stall), 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        #4;
        chk("rst_busy:stall", 32'(stall), 32'd0);
        chk("rst_busy:rvalid", 32'(rvalid), 32'd0);
        chk("rst_busy:rdata", rdata, 32'd0);
        chk("rst_busy:misalign", 32'(misalign), 32'd0);
        last_rdata = '0;
        @(posedge clk); #1;
        access(1, 0, 3'b010, 32'h0100_0020, 32'h0, "lw_after_rst");

        access(0, 1, 3'b010, 32'h0100_0000, 32'h1122_3344, "sw_pre_sh");
        access(0, 1, 3'b001, 32'h0100_0001, 32'h0000_A5C3, "sh_mis");
        access(1, 0, 3'b010, 32'h0100_0000, 32'h0, "lw_post_sh");
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("sh_mis:word", rdata, 32'h1122_3344);
`else
        chk("sh_mis:word", rdata, 32'h1122_A5C3);
`endif

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 7);
            if (sel == 0) ra = BASE - 4 * $urandom_range(1, 4);
            else if (sel == 1) ra = BASE + DEPTH * 4 + $urandom_range(0, 15);
            else ra = BASE + $urandom_range(0, 63);
            rf = f3_list[$urandom_range(0, 6)];
            rw = $urandom();
            op = $urandom_range(0, 3);
            access(op != 1, op == 1 || op == 2, rf, ra, rw, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
